mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between instruction fetch (read-only) and the MEM

---
 rtl/mem_port_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported unified memory between instruction fetch (read
// only) and the MEM stage (load/store). Exactly one memory transaction is in
// flight at a time; the response is routed back to the requester that owns
// it. A fetch squashed by if_kill still completes on the memory side, but
// its response is swallowed.
//
// Handshake rules (all ports):
//   Requester side: *_req is raised together with its attributes and held
//   stable until the matching *_rvalid pulse (a fetch may instead be
//   abandoned with if_kill). *_rvalid is a single-cycle pulse carrying
//   *_rdata (or, for stores, signalling completion).
//   Memory side: mem_req and every mem_* attribute stay stable from the
//   first ISSUE cycle until the cycle mem_gnt is seen high. mem_rvalid is
//   honoured only while a granted transaction is waiting for its response.
//
// Configuration macro:
//   MEM_PORT_ARB_RR_EN  defined   -> round-robin on ties (last_owner register,
//                                    reset to IF so dm wins the first tie)
//                       undefined -> fixed priority, dm over if
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-low reset
//   if_req/if_addr/if_kill  fetch request, address, squash
//   if_rvalid/if_rdata      fetch response pulse and instruction word
//   dm_req/dm_we/dm_addr/dm_wdata/dm_be   data request and attributes
//   dm_rvalid/dm_rdata      data response pulse and load data
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be   memory request side
//   mem_gnt/mem_rvalid/mem_rdata               memory accept / response
//   busy                    a transaction is in flight (state != IDLE)
//   fsm_state               current FSM state (debug / checker visibility)
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_kill,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic [1:0]          fsm_state
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

    state_t              state, state_next;
    owner_t              owner;
    logic                kill_pending, kill_pending_next;

    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                if_cand, dm_cand, pick_dm, load;
    logic                resp_take, resp_if, resp_dm;

`ifdef MEM_PORT_ARB_RR_EN
    owner_t              last_owner;
`endif

    // ------------------------------------------------------------------
    // Next state, arbitration and response routing
    // ------------------------------------------------------------------
    always_comb begin
        state_next        = state;
        load              = 1'b0;
        kill_pending_next = kill_pending;

        // A killed fetch is never eligible in the same cycle. While
        // arbitrating on a response, the owner just served is excluded:
        // its req is still high until it sees its rvalid next cycle.
        if_cand = if_req && !if_kill && !(state == S_WAIT && owner == OWN_IF);
        dm_cand = dm_req && !(state == S_WAIT && owner == OWN_DM);

`ifdef MEM_PORT_ARB_RR_EN
        pick_dm = dm_cand && (!if_cand || last_owner != OWN_DM);
`else
        pick_dm = dm_cand;
`endif

        resp_take = (state == S_WAIT) && mem_rvalid;
        // A kill in the response cycle itself also drops the response.
        resp_if   = resp_take && owner == OWN_IF && !kill_pending && !if_kill;
        resp_dm   = resp_take && owner == OWN_DM;

        if (resp_take) begin
            kill_pending_next = 1'b0;
        end else if ((state == S_ISSUE || state == S_WAIT) && owner == OWN_IF && if_kill) begin
            kill_pending_next = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (if_cand || dm_cand) begin
                    load       = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_gnt) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    if (if_cand || dm_cand) begin
                        load       = 1'b1;
                        state_next = S_ISSUE;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, request capture and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            owner        <= OWN_NONE;
            kill_pending <= 1'b0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            be_q         <= '0;
            rdata_q      <= '0;
            if_rvalid    <= 1'b0;
            dm_rvalid    <= 1'b0;
        end else begin
            state        <= state_next;
            kill_pending <= kill_pending_next;
            if_rvalid    <= resp_if;
            dm_rvalid    <= resp_dm;
            if (resp_take) begin
                rdata_q <= mem_rdata;
            end
            if (load) begin
                if (pick_dm) begin
                    owner   <= OWN_DM;
                    addr_q  <= dm_addr;
                    we_q    <= dm_we;
                    wdata_q <= dm_wdata;
                    // Byte enables only matter for stores; reads fetch the full word.
                    be_q    <= dm_we ? dm_be : '1;
                end else begin
                    owner   <= OWN_IF;
                    addr_q  <= if_addr;
                    we_q    <= 1'b0;
                    wdata_q <= '0;
                    be_q    <= '1;
                end
            end else if (resp_take) begin
                owner <= OWN_NONE;
            end
        end
    end

`ifdef MEM_PORT_ARB_RR_EN
    // Reset to IF so the very first tie goes to the data side.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner <= OWN_IF;
        end else if (load) begin
            last_owner <= pick_dm ? OWN_DM : OWN_IF;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_req   = (state == S_ISSUE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign if_rdata  = rdata_q;
    assign dm_rdata  = rdata_q;
    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_kill, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_rvalid;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        busy;
    logic [1:0]  fsm_state;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .fsm_state(fsm_state)
    );

`ifdef MEM_PORT_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        bit          is_dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          gw;   // cycles mem_gnt is held low
        int          rw;   // extra cycles between gnt and mem_rvalid
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Scoreboards: {check_data, is_dm, data} and {we, be, addr, wdata}.
    logic [33:0] exp_q[$];
    logic [68:0] exp_mem_q[$];

    logic [31:0] ref_mem [0:255];
    logic [31:0] sim_mem [0:255];
    int gnt_wait = 0;
    int rsp_wait = 0;

    task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: event seen, none expected", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Memory responder: grants after gnt_wait cycles, answers rw cycles
    // after the grant cycle, checks request fields against exp_mem_q.
    // ------------------------------------------------------------------
    initial begin
        int          phase;
        int          cnt;
        logic [68:0] cap;
        logic        r_we;
        logic [3:0]  r_be;
        logic [31:0] r_addr, r_wdata;
        phase = 0;
        cnt = 0;
        cap = '0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        forever begin
            tick();
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata = $urandom;
            case (phase)
                0: if (mem_req) begin
                    r_we = mem_we; r_be = mem_be; r_addr = mem_addr; r_wdata = mem_wdata;
                    cap = {r_we, r_be, r_addr, (r_we ? r_wdata : 32'h0)};
                    if (exp_mem_q.size() == 0) fail_now("mem_unexpected_req");
                    else check("mem_fields", cap, exp_mem_q.pop_front());
                    if (gnt_wait == 0) begin
                        mem_gnt = 1'b1; phase = 2; cnt = rsp_wait;
                    end else begin
                        cnt = gnt_wait; phase = 1;
                    end
                end
                1: begin
                    check("stall_mem_req", {68'h0, mem_req}, 69'h1);
                    check("stall_fields", {mem_we, mem_be, mem_addr, (mem_we ? mem_wdata : 32'h0)}, cap);
                    check("stall_busy", {68'h0, busy}, 69'h1);
                    cnt--;
                    if (cnt == 0) begin
                        mem_gnt = 1'b1; phase = 2; cnt = rsp_wait;
                    end
                end
                default: begin
                    if (cnt == 0) begin
                        mem_rvalid = 1'b1;
                        if (r_we) begin
                            for (int b = 0; b < 4; b++)
                                if (r_be[b]) sim_mem[r_addr[9:2]][8*b +: 8] = r_wdata[8*b +: 8];
                        end else begin
                            mem_rdata = sim_mem[r_addr[9:2]];
                        end
                        phase = 0;
                    end else begin
                        cnt--;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Response monitor: pops the expected queue on every rvalid pulse.
    // ------------------------------------------------------------------
    initial begin
        logic [33:0] e;
        forever begin
            tick();
            if (if_rvalid && dm_rvalid) begin
                fail_now("both_rvalid");
            end else if (if_rvalid || dm_rvalid) begin
                if (exp_q.size() == 0) begin
                    fail_now(dm_rvalid ? "unexpected_dm_rvalid" : "unexpected_if_rvalid");
                end else begin
                    e = exp_q.pop_front();
                    check("rvalid_owner", {68'h0, dm_rvalid}, {68'h0, e[32]});
                    if (e[33]) check("rdata", {37'h0, (dm_rvalid ? dm_rdata : if_rdata)}, {37'h0, e[31:0]});
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic expect_txn(input vec_t v, input bit resp);
        logic [7:0] idx;
        idx = v.addr[9:2];
        if (v.is_dm && v.we) begin
            exp_mem_q.push_back({1'b1, v.be, v.addr, v.wdata});
            for (int b = 0; b < 4; b++)
                if (v.be[b]) ref_mem[idx][8*b +: 8] = v.wdata[8*b +: 8];
            if (resp) exp_q.push_back({1'b0, 1'b1, 32'h0});
        end else begin
            exp_mem_q.push_back({1'b0, 4'hF, v.addr, 32'h0});
            if (resp) exp_q.push_back({1'b1, v.is_dm, ref_mem[idx]});
        end
    endtask

    task automatic drive(input vec_t v);
        if (v.is_dm) begin
            dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata; dm_be = v.be;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
    endtask

    // kill_at >= 1 on a fetch: pulse if_kill (and drop if_req) in that cycle.
    // kill_at >= 0 on a dm access: pulse if_kill, which must have no effect.
    task automatic run_vec(input vec_t v, input int kill_at);
        int n;
        int seen;
        bit got;
        gnt_wait = v.gw;
        rsp_wait = v.rw;
        if (!v.is_dm && kill_at >= 1) begin
            expect_txn(v, 1'b0);
            drive(v);
            seen = 0;
            for (int k = 0; k < 9; k++) begin
                if (k == kill_at) begin
                    if_kill = 1'b1; if_req = 1'b0;
                end else begin
                    if_kill = 1'b0;
                end
                tick();
                if (if_rvalid) seen++;
            end
            if_kill = 1'b0;
            check("kill_no_rvalid", 69'(seen), 69'd0);
            check("kill_back_idle", {68'h0, busy}, 69'h0);
        end else begin
            expect_txn(v, 1'b1);
            drive(v);
            n = 0;
            got = 1'b0;
            while (!got && n < 40) begin
                if_kill = (n == kill_at);
                tick();
                n++;
                got = v.is_dm ? dm_rvalid : if_rvalid;
            end
            if_kill = 1'b0;
            check("latency", 69'(n), 69'(3 + v.gw + v.rw));
            if (v.is_dm) dm_req = 1'b0; else if_req = 1'b0;
        end
    endtask

    // Both requesters raised in the same cycle from IDLE, 0-wait memory.
    task automatic run_pair(input vec_t fv, input vec_t dv, input bit dm_first);
        int n, t_if, t_dm;
        gnt_wait = 0;
        rsp_wait = 0;
        if (dm_first) begin
            expect_txn(dv, 1'b1); expect_txn(fv, 1'b1);
        end else begin
            expect_txn(fv, 1'b1); expect_txn(dv, 1'b1);
        end
        drive(fv);
        drive(dv);
        n = 0; t_if = -1; t_dm = -1;
        while ((t_if < 0 || t_dm < 0) && n < 40) begin
            tick();
            n++;
            if (if_rvalid && t_if < 0) begin t_if = n; if_req = 1'b0; end
            if (dm_rvalid && t_dm < 0) begin t_dm = n; dm_req = 1'b0; end
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        check("pair_first",  69'(dm_first ? t_dm : t_if), 69'd3);
        check("pair_second", 69'(dm_first ? t_if : t_dm), 69'd5);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    vec_t tbl[14];

    initial begin
        vec_t v;
        int seen;

        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 32'hC0DE0000 | 32'(i);
            sim_mem[i] = 32'hC0DE0000 | 32'(i);
        end
        ref_mem[8'h40] = 32'h00000013;
        sim_mem[8'h40] = 32'h00000013;

        tbl[0] = '{1'b0, 1'b0, 32'h100, 32'h0,        4'hF, 0, 0};
        tbl[1] = '{1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 4'b0011, 0, 0};
        tbl[2] = '{1'b1, 1'b0, 32'h200, 32'h0,        4'b0101, 0, 0};
        tbl[3] = '{1'b1, 1'b1, 32'h204, 32'h12345678, 4'b1111, 5, 1};
        tbl[4] = '{1'b1, 1'b0, 32'h204, 32'h0,        4'b0001, 1, 3};
        tbl[5] = '{1'b0, 1'b0, 32'h104, 32'h0,        4'hF, 3, 0};
        tbl[6] = '{1'b1, 1'b1, 32'h208, 32'hAABBCCDD, 4'b1000, 0, 2};
        tbl[7] = '{1'b1, 1'b0, 32'h208, 32'h0,        4'b0000, 0, 0};
        for (int i = 8; i < 14; i++) begin
            tbl[i].is_dm = ($urandom_range(0, 1) == 1);
            tbl[i].we    = tbl[i].is_dm && ($urandom_range(0, 1) == 1);
            tbl[i].addr  = 32'($urandom_range(0, 255)) << 2;
            tbl[i].wdata = $urandom;
            tbl[i].be    = 4'($urandom_range(1, 15));
            tbl[i].gw    = $urandom_range(0, 3);
            tbl[i].rw    = $urandom_range(0, 3);
        end

        reset = 1'b0;
        if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
        repeat (3) tick();
        check("reset_ctrl", {60'h0, if_rvalid, dm_rvalid, mem_req, mem_we, mem_be, busy, fsm_state}, 69'h0);
        check("reset_data", {5'h0, mem_addr, mem_wdata}, 69'h0);
        reset = 1'b1;
        tick();

        // Single-requester vectors, each starting from IDLE.
        for (int i = 0; i < 14; i++) begin
            run_vec(tbl[i], -1);
            tick();
        end

        // Ties: after a dm-only access, then after a fetch-only access.
        run_vec('{1'b1, 1'b0, 32'h210, 32'h0, 4'hF, 0, 0}, -1);
        run_pair('{1'b0, 1'b0, 32'h108, 32'h0, 4'hF, 0, 0},
                 '{1'b1, 1'b0, 32'h214, 32'h0, 4'hF, 0, 0}, !RR);
        tick();
        run_vec('{1'b0, 1'b0, 32'h10C, 32'h0, 4'hF, 0, 0}, -1);
        run_pair('{1'b0, 1'b0, 32'h110, 32'h0, 4'hF, 0, 0},
                 '{1'b1, 1'b0, 32'h218, 32'h0, 4'hF, 0, 0}, 1'b1);
        tick();

        // Kills: in WAIT, in the response cycle, in ISSUE; then normal fetch.
        run_vec('{1'b0, 1'b0, 32'h104, 32'h0, 4'hF, 0, 2}, 2);
        run_vec('{1'b0, 1'b0, 32'h110, 32'h0, 4'hF, 0, 2}, 4);
        run_vec('{1'b0, 1'b0, 32'h114, 32'h0, 4'hF, 2, 0}, 1);
        run_vec('{1'b0, 1'b0, 32'h300, 32'h0, 4'hF, 0, 0}, -1);
        tick();

        // if_kill pulse during a dm-owned transaction has no effect.
        run_vec('{1'b1, 1'b0, 32'h21C, 32'h0, 4'hF, 0, 1}, 2);
        tick();

        // Kill in IDLE: fetch not granted that cycle, then served normally.
        if_req = 1'b1; if_addr = 32'h118; if_kill = 1'b1;
        tick();
        check("idle_kill_no_grant", {68'h0, busy}, 69'h0);
        if_kill = 1'b0;
        run_vec('{1'b0, 1'b0, 32'h118, 32'h0, 4'hF, 0, 0}, -1);
        tick();

        // Reset during WAIT, stray mem_rvalid after release.
        v = '{1'b1, 1'b0, 32'h220, 32'h0, 4'hF, 0, 3};
        gnt_wait = v.gw;
        rsp_wait = v.rw;
        expect_txn(v, 1'b0);
        drive(v);
        repeat (3) tick();
        check("pre_reset_wait", {67'h0, fsm_state}, 69'd2);
        reset = 1'b0;
        dm_req = 1'b0;
        #1;
        check("midreset_ctrl", {60'h0, if_rvalid, dm_rvalid, mem_req, mem_we, mem_be, busy, fsm_state}, 69'h0);
        check("midreset_data", {5'h0, mem_addr, mem_wdata}, 69'h0);
        check("midreset_rdata", {5'h0, if_rdata, dm_rdata}, 69'h0);
        tick();
        reset = 1'b1;
        seen = 0;
        repeat (5) begin
            tick();
            if (if_rvalid || dm_rvalid) seen++;
        end
        check("stray_rvalid_ignored", 69'(seen), 69'd0);
        check("stray_busy", {68'h0, busy}, 69'h0);

        repeat (3) tick();
        check("exp_q_drained", 69'(exp_q.size()), 69'd0);
        check("exp_mem_q_drained", 69'(exp_mem_q.size()), 69'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
